// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: HUD "TIME" sequencer.
// Counts game seconds down from START_SECONDS and drives the two BCD digits.
// Blinks the TIME header while time is low, and flags time-up to the game FSM.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | after reset, count frozen, waiting for startGame
// RUN      | prescaler running, count decrements once per game second
// PAUSE    | prescaler, count and blink phase held while pauseReq is high
// EXPIRED  | count reached zero, timeOver high until startGame or reset
module game_timer_ctrl #(
    parameter int CLK_FREQ_HZ   = 31_500_000,
    parameter int START_SECONDS = 99,
    parameter int WARN_SECONDS  = 10,
    parameter int BONUS_SECONDS = 5,
    parameter int BLINK_HALF    = CLK_FREQ_HZ / 4
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startGame,
    input  logic       pauseReq,
    input  logic       bonusPulse,
    output logic [3:0] tensDigit,
    output logic [3:0] unitsDigit,
    output logic       headerVisible,
    output logic       warning,
    output logic       timeUp,
    output logic       timeOver
);

    localparam int PRESC_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(CLK_FREQ_HZ - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_HALF - 1);
    localparam logic [6:0]         START_CNT   = 7'(START_SECONDS);
    localparam logic [6:0]         WARN_CNT    = 7'(WARN_SECONDS);
    localparam logic [7:0]         BONUS_ADD   = 8'(BONUS_SECONDS);
    localparam logic [7:0]         MAX_CNT     = 8'd99;
    localparam logic [3:0]         START_TENS  = 4'(START_SECONDS / 10);
    localparam logic [3:0]         START_UNITS = 4'(START_SECONDS % 10);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [6:0]         count;
    logic [6:0]         count_next;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_next;
    logic [BLINK_W-1:0] blink;
    logic [7:0]         sum;
    logic               tick;
    logic               time_up_next;
    logic               warn_now;

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, prescaler/tick and saturating count update.
    // A pause request stops the prescaler in the same cycle it is seen, so the
    // prescaler phase is preserved exactly across the pause.
    always_comb begin
        state_next   = state;
        count_next   = count;
        presc_next   = presc;
        tick         = 1'b0;
        time_up_next = 1'b0;
        sum          = {1'b0, count};
        if (startGame) begin
            state_next = ST_RUN;
            count_next = START_CNT;
            presc_next = '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!pauseReq) begin
                        tick       = (presc == PRESC_LAST);
                        presc_next = tick ? '0 : presc + PRESC_W'(1);
                    end
                    sum = {1'b0, count} + (bonusPulse ? BONUS_ADD : 8'd0) - {7'd0, tick};
                    count_next = (sum > MAX_CNT) ? 7'd99 : sum[6:0];
                    if (sum == 8'd0) begin
                        state_next   = ST_EXPIRED;
                        time_up_next = 1'b1;
                    end else if (pauseReq) begin
                        state_next = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (!pauseReq) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Low-time condition from the current count, registered below with the digits.
    always_comb begin
        warn_now = 1'b0;
        if ((state == ST_RUN) || (state == ST_PAUSE)) begin
            warn_now = (count <= WARN_CNT) && (count != 7'd0);
        end
    end

    // Count, prescaler, time-up pulse and registered display outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count      <= START_CNT;
            presc      <= '0;
            timeUp     <= 1'b0;
            tensDigit  <= START_TENS;
            unitsDigit <= START_UNITS;
            warning    <= 1'b0;
        end else begin
            count      <= count_next;
            presc      <= presc_next;
            timeUp     <= time_up_next;
            tensDigit  <= 4'(count / 7'd10);
            unitsDigit <= 4'(count % 7'd10);
            warning    <= warn_now;
        end
    end

    // Header blink: restarts visible when warning rises, freezes in PAUSE,
    // and is forced visible whenever the warning is not blinking in RUN.
    // Keyed on warn_now so headerVisible settles in the same cycle as warning.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blink         <= '0;
            headerVisible <= 1'b1;
        end else if (startGame) begin
            blink         <= '0;
            headerVisible <= 1'b1;
        end else if ((state == ST_RUN) && warn_now) begin
            if (!warning) begin
                blink         <= '0;
                headerVisible <= 1'b1;
            end else if (blink == BLINK_LAST) begin
                blink         <= '0;
                headerVisible <= ~headerVisible;
            end else begin
                blink <= blink + BLINK_W'(1);
            end
        end else if (state != ST_PAUSE) begin
            blink         <= '0;
            headerVisible <= 1'b1;
        end
    end

    assign timeOver = (state == ST_EXPIRED);

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl with small timing parameters
// (1 s = 10 clk, start 12, warn at 3, bonus 5, blink half-period 2).
module tb_game_timer_ctrl;

    logic       clk;
    logic       resetN;
    logic       startGame;
    logic       pauseReq;
    logic       bonusPulse;
    logic [3:0] tensDigit;
    logic [3:0] unitsDigit;
    logic       headerVisible;
    logic       warning;
    logic       timeUp;
    logic       timeOver;

    int checks   = 0;
    int failures = 0;

    game_timer_ctrl #(
        .CLK_FREQ_HZ  (10),
        .START_SECONDS(12),
        .WARN_SECONDS (3),
        .BONUS_SECONDS(5),
        .BLINK_HALF   (2)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startGame    (startGame),
        .pauseReq     (pauseReq),
        .bonusPulse   (bonusPulse),
        .tensDigit    (tensDigit),
        .unitsDigit   (unitsDigit),
        .headerVisible(headerVisible),
        .warning      (warning),
        .timeUp       (timeUp),
        .timeOver     (timeOver)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       pause;
        logic       bonus;
        int         n;
        logic [3:0] tens;
        logic [3:0] units;
        logic       warn;
        logic       hv;
        logic       tu;
        logic       to;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [11:0] outs();
        return {tensDigit, unitsDigit, warning, headerVisible, timeUp, timeOver};
    endfunction

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full output vector: {tens, units, warning, headerVisible, timeUp, timeOver}.
    task automatic check_all(input string name, input logic [11:0] exp);
        logic [11:0] got;
        got = outs();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s outs got=%03h exp=%03h", name, got, exp);
        end
    endtask

    task automatic check_digits(input string name, input logic [3:0] t, input logic [3:0] u);
        checks++;
        if ({tensDigit, unitsDigit} !== {t, u}) begin
            failures++;
            $display("FAIL %s digits got=%0d%0d exp=%0d%0d", name, tensDigit, unitsDigit, t, u);
        end
    endtask

    task automatic check_flags(input string name, input logic tu, input logic to);
        checks++;
        if ({timeUp, timeOver} !== {tu, to}) begin
            failures++;
            $display("FAIL %s timeUp/timeOver got=%b%b exp=%b%b", name, timeUp, timeOver, tu, to);
        end
    endtask

    task automatic pulse_start();
        startGame = 1'b1;
        step(1);
        startGame = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Edge indices in comments are counted from the startGame edge (E0).
        vecs[0]  = '{1'b1, 1'b0, 1'b0,  1, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0}; // E0
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 11, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0}; // E11
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 10, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}; // E21
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 69, 4'd0, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0}; // E90
        vecs[4]  = '{1'b0, 1'b0, 1'b0,  1, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0}; // E91 warning rises
        vecs[5]  = '{1'b0, 1'b0, 1'b0,  1, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0}; // E92
        vecs[6]  = '{1'b0, 1'b0, 1'b0,  1, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0}; // E93
        vecs[7]  = '{1'b0, 1'b0, 1'b0,  1, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0}; // E94
        vecs[8]  = '{1'b0, 1'b0, 1'b0,  1, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0}; // E95
        vecs[9]  = '{1'b0, 1'b0, 1'b0,  1, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0}; // E96
        vecs[10] = '{1'b0, 1'b0, 1'b0, 24, 4'd0, 4'd1, 1'b1, 1'b1, 1'b1, 1'b1}; // E120 expiry
        vecs[11] = '{1'b0, 1'b0, 1'b0,  1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1}; // E121
        vecs[12] = '{1'b0, 1'b0, 1'b0,  5, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1}; // E126

        resetN     = 1'b0;
        startGame  = 1'b0;
        pauseReq   = 1'b0;
        bonusPulse = 1'b0;
        step(3);
        check_all("reset_held", {4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0});
        resetN = 1'b1;
        step(4);
        check_all("idle_after_reset", {4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0});

        // Full countdown, warning blink and expiry.
        for (int i = 0; i < 13; i++) begin
            startGame  = vecs[i].start;
            pauseReq   = vecs[i].pause;
            bonusPulse = vecs[i].bonus;
            step(vecs[i].n);
            startGame  = 1'b0;
            bonusPulse = 1'b0;
            check_all($sformatf("vec%0d", i),
                      {vecs[i].tens, vecs[i].units, vecs[i].warn, vecs[i].hv, vecs[i].tu, vecs[i].to});
        end

        // startGame from EXPIRED: reload, prescaler restarts at 0.
        pulse_start();
        step(1);
        check_digits("restart_expired", 4'd1, 4'd2);
        check_flags("restart_expired_flags", 1'b0, 1'b0);
        step(9);
        check_digits("restart_expired_e10", 4'd1, 4'd2);
        step(1);
        check_digits("restart_expired_e11", 4'd1, 4'd1);

        // startGame from PAUSE (prescaler held at 5) must restart prescaler at 0.
        pulse_start();
        step(25);
        pauseReq = 1'b1;
        step(5);
        pauseReq  = 1'b0;
        startGame = 1'b1;
        step(1);
        startGame = 1'b0;
        step(1);
        check_digits("restart_pause", 4'd1, 4'd2);
        step(9);
        check_digits("restart_pause_e41", 4'd1, 4'd2);
        step(1);
        check_digits("restart_pause_e42", 4'd1, 4'd1);

        // startGame with bonus in the same cycle: bonus ignored.
        startGame  = 1'b1;
        bonusPulse = 1'b1;
        step(1);
        startGame  = 1'b0;
        bonusPulse = 1'b0;
        step(2);
        check_digits("start_with_bonus", 4'd1, 4'd2);

        // Pause 25 clks at count 7 with prescaler at 3.
        pulse_start();
        step(53);
        pauseReq = 1'b1;
        step(17);
        check_digits("pause_e70", 4'd0, 4'd7);
        step(8);
        check_digits("pause_e78", 4'd0, 4'd7);
        pauseReq = 1'b0;
        step(7);
        check_digits("resume_e85", 4'd0, 4'd7);
        step(1);
        check_digits("resume_e86", 4'd0, 4'd7);
        step(1);
        check_digits("resume_e87", 4'd0, 4'd6);

        // Bonus coinciding with the tick at count 1: count 5, no expiry.
        pulse_start();
        step(119);
        bonusPulse = 1'b1;
        step(1);
        bonusPulse = 1'b0;
        check_flags("bonus_at_one_flags", 1'b0, 1'b0);
        step(1);
        check_all("bonus_at_one", {4'd0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0});

        // Saturation: reach 92, then bonus to 97, then bonus clamps at 99.
        pulse_start();
        bonusPulse = 1'b1;
        step(17);
        bonusPulse = 1'b0;
        step(33);
        check_digits("sat_e50", 4'd9, 4'd3);
        bonusPulse = 1'b1;
        step(1);
        check_digits("sat_e51", 4'd9, 4'd2);
        step(1);
        bonusPulse = 1'b0;
        check_digits("sat_e52", 4'd9, 4'd7);
        step(1);
        check_digits("sat_e53", 4'd9, 4'd9);

        // Asynchronous reset mid-game at count 5.
        pulse_start();
        step(75);
        check_digits("pre_reset", 4'd0, 4'd5);
        #2;
        resetN = 1'b0;
        #1;
        check_all("async_reset", {4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0});
        resetN = 1'b1;
        step(1);
        bonusPulse = 1'b1;
        step(1);
        bonusPulse = 1'b0;
        step(29);
        check_all("idle_frozen", {4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
